// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bnn_pkg
// Brief    : Shared BNN constants (conv3 map size, FC word width) and FSM states
// Revision : 1.0
// ============================================================================
package bnn_pkg;

    localparam int c_CONV3_W = 12;
    localparam int c_CONV3_H = 12;
    localparam int c_FC_WORD = 12;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bnn_pool_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : bnn_pool_collector_if
// Brief    : Pool window stream in, packed FC words out
// Revision : 1.0
// ============================================================================
interface bnn_pool_collector_if import bnn_pkg::*; #(
    parameter int WORD = c_FC_WORD
);
    logic            iSTART;
    logic            iSEL_AND;
    logic            iDATA_OR;
    logic            iDATA_AND;
    logic [WORD-1:0] oWORD;
    logic            oVALID;
    logic            oDONE;
    logic            oBUSY;

    modport master (
        output iSTART, iSEL_AND, iDATA_OR, iDATA_AND,
        input  oWORD, oVALID, oDONE, oBUSY
    );

    modport slave (
        input  iSTART, iSEL_AND, iDATA_OR, iDATA_AND,
        output oWORD, oVALID, oDONE, oBUSY
    );
endinterface
`default_nettype wire

// File: rtl/bnn_pos_cnt.sv
`default_nettype none
// ============================================================================
// Module   : bnn_pos_cnt
// Brief    : Row/col tracker for a row-major pixel stream with stride-2 capture flag
// Revision : 1.0
// ============================================================================
module bnn_pos_cnt #(
    parameter int W = 12,
    parameter int H = 12
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_start,
    input  wire logic i_run,
    output logic      o_last,
    output logic      o_capture
);
    localparam int c_CW = $clog2(W);
    localparam int c_RW = $clog2(H);
    localparam logic [c_CW-1:0] c_COL_MAX = c_CW'(W - 1);
    localparam logic [c_CW-1:0] c_COL_ONE = c_CW'(1);
    localparam logic [c_RW-1:0] c_ROW_MAX = c_RW'(H - 1);
    localparam logic [c_RW-1:0] c_ROW_ONE = c_RW'(1);

    logic [c_CW-1:0] r_col;
    logic [c_RW-1:0] r_row;
    logic            w_active;

    // Pixel (0,0) is consumed in the start cycle itself, so the count resumes at column 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_start) begin
            r_col <= c_COL_ONE;
            r_row <= '0;
        end else if (i_run) begin
            if (r_col == c_COL_MAX) begin
                r_col <= '0;
                r_row <= (r_row == c_ROW_MAX) ? '0 : r_row + c_ROW_ONE;
            end else begin
                r_col <= r_col + c_COL_ONE;
            end
        end
    end

    assign w_active  = i_run && !i_start;
    assign o_last    = w_active && (r_col == c_COL_MAX) && (r_row == c_ROW_MAX);
    assign o_capture = w_active && r_col[0] && r_row[0];

endmodule
`default_nettype wire

// File: rtl/bnn_pool_collector.sv
`default_nettype none
// ============================================================================
// Module   : bnn_pool_collector
// Brief    : Keeps stride-2 max/min-pool windows and packs them LSB-first into FC words
// Revision : 1.0
// ============================================================================
module bnn_pool_collector import bnn_pkg::*; #(
    parameter int W    = c_CONV3_W,
    parameter int H    = c_CONV3_H,
    parameter int WORD = c_FC_WORD
) (
    input wire logic            iCLK,
    input wire logic            iRST,
    bnn_pool_collector_if.slave bus
);
    localparam int c_NWORDS = (W / 2) * (H / 2) / WORD;
    localparam int c_BCW    = $clog2(WORD);
    localparam int c_WCW    = $clog2(c_NWORDS + 1);
    localparam logic [c_BCW-1:0] c_BIT_LAST  = c_BCW'(WORD - 1);
    localparam logic [c_BCW-1:0] c_BIT_ONE   = c_BCW'(1);
    localparam logic [c_WCW-1:0] c_WORD_LAST = c_WCW'(c_NWORDS - 1);
    localparam logic [c_WCW-1:0] c_WORD_ONE  = c_WCW'(1);

    state_t           r_state;
    logic             r_busy;
    logic             r_pend;
    logic             r_valid;
    logic             r_done;
    logic [WORD-1:0]  r_acc;
    logic [WORD-1:0]  r_word;
    logic [WORD-1:0]  w_accNext;
    logic [c_BCW-1:0] r_bitCnt;
    logic [c_WCW-1:0] r_wordCnt;
    logic             w_run;
    logic             w_abort;
    logic             w_last;
    logic             w_capture;
    logic             w_bit;

    assign w_run   = (r_state == S_RUN);
    assign w_abort = w_run && bus.iSTART;
    assign w_bit   = bus.iSEL_AND ? bus.iDATA_AND : bus.iDATA_OR;

    bnn_pos_cnt #(
        .W (W),
        .H (H)
    ) u_posCnt (
        .clk       (iCLK),
        .rst       (iRST),
        .i_start   (bus.iSTART),
        .i_run     (w_run),
        .o_last    (w_last),
        .o_capture (w_capture)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.iSTART) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    r_state <= bus.iSTART ? S_RUN : S_IDLE;
                    r_busy  <= bus.iSTART;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_accNext           = r_acc;
        w_accNext[r_bitCnt] = w_bit;
    end

    // A restart mid-frame drops the pending capture and the partial word; in FLUSH the
    // final capture still completes since that path never sees w_abort.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_pend    <= 1'b0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_acc     <= '0;
            r_word    <= '0;
            r_bitCnt  <= '0;
            r_wordCnt <= '0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (w_abort) begin
                r_pend    <= 1'b0;
                r_acc     <= '0;
                r_bitCnt  <= '0;
                r_wordCnt <= '0;
            end else begin
                r_pend <= w_capture;
                if (r_pend) begin
                    if (r_bitCnt == c_BIT_LAST) begin
                        r_word   <= w_accNext;
                        r_valid  <= 1'b1;
                        r_acc    <= '0;
                        r_bitCnt <= '0;
                        if (r_wordCnt == c_WORD_LAST) begin
                            r_done    <= 1'b1;
                            r_wordCnt <= '0;
                        end else begin
                            r_wordCnt <= r_wordCnt + c_WORD_ONE;
                        end
                    end else begin
                        r_acc    <= w_accNext;
                        r_bitCnt <= r_bitCnt + c_BIT_ONE;
                    end
                end
            end
        end
    end

    assign bus.oWORD  = r_word;
    assign bus.oVALID = r_valid;
    assign bus.oDONE  = r_done;
    assign bus.oBUSY  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bnn_pool_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_bnn_pool_collector
// Brief    : Scoreboard bench: 2x2 pool model feeds the collector, words checked on oVALID
// Revision : 1.0
// ============================================================================
module tb_bnn_pool_collector;
    localparam int W      = 12;
    localparam int H      = 12;
    localparam int WORD   = 12;
    localparam int NPIX   = W * H;
    localparam int NWORDS = (W / 2) * (H / 2) / WORD;

    typedef struct {
        logic [WORD-1:0] word;
        logic            done;
        int              at;
    } exp_t;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    logic img [H][W];
    logic carrySel, carryOr, carryAnd;

    bnn_pool_collector_if #(.WORD(WORD)) bus();

    bnn_pool_collector #(
        .W    (W),
        .H    (H),
        .WORD (WORD)
    ) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // 2x2 window ending at (r,c): OR is the +1-encoded max, AND the min.
    function automatic logic pool(input int r, input int c, input logic m);
        logic a, b, d, e;
        a = img[r-1][c-1];
        b = img[r-1][c];
        d = img[r][c-1];
        e = img[r][c];
        return m ? (a & b & d & e) : (a | b | d | e);
    endfunction

    task automatic pix_vals(input int p, input logic mode, output logic s, output logic o, output logic a);
        int   r, c;
        logic v;
        r = p / W;
        c = p % W;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            v = pool(r, c, mode);
            s = mode;
            o = mode ? ~v : v;
            a = mode ? v : ~v;
        end else begin
            s = 1'($urandom_range(0, 1));
            o = 1'($urandom_range(0, 1));
            a = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic fill(input int val, input logic rnd);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = rnd ? 1'($urandom_range(0, 1)) : 1'(val);
    endtask

    // Drives len cycles of a frame starting with iSTART; a len shorter than the frame
    // is cut short by whatever comes next (restart or reset).
    task automatic run_frame(input logic mode, input int len);
        int              e0, bc, wc, r, c;
        logic [WORD-1:0] acc;
        logic            s, o, a;
        @(posedge iCLK); #1;
        e0  = cyc;
        bc  = 0;
        wc  = 0;
        acc = '0;
        for (int k = 0; k < NPIX; k++) begin
            r = k / W;
            c = k % W;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                acc[bc] = pool(r, c, mode);
                bc++;
                if (bc == WORD) begin
                    if (len == NPIX || k + 1 < len)
                        q.push_back('{word: acc, done: (wc == NWORDS - 1), at: e0 + k + 2});
                    wc++;
                    bc  = 0;
                    acc = '0;
                end
            end
        end
        for (int j = 0; j < len; j++) begin
            if (j > 0) begin
                @(posedge iCLK); #1;
            end
            bus.iSTART = (j == 0);
            if (j == 0) begin
                s = carrySel; o = carryOr; a = carryAnd;
            end else begin
                pix_vals(j - 1, mode, s, o, a);
            end
            bus.iSEL_AND  = s;
            bus.iDATA_OR  = o;
            bus.iDATA_AND = a;
            if (j == 1) begin
                @(negedge iCLK);
                chk("busy_run", bus.oBUSY, 1);
            end
        end
        pix_vals(len - 1, mode, carrySel, carryOr, carryAnd);
    endtask

    task automatic idle(input int n, input logic checkBusy);
        for (int j = 0; j < n; j++) begin
            @(posedge iCLK); #1;
            bus.iSTART = 1'b0;
            if (j == 0) begin
                bus.iSEL_AND = carrySel; bus.iDATA_OR = carryOr; bus.iDATA_AND = carryAnd;
            end else begin
                bus.iSEL_AND  = 1'($urandom_range(0, 1));
                bus.iDATA_OR  = 1'($urandom_range(0, 1));
                bus.iDATA_AND = 1'($urandom_range(0, 1));
            end
            if (checkBusy && j < 2) begin
                @(negedge iCLK);
                chk(j == 0 ? "busy_flush" : "busy_idle", bus.oBUSY, (j == 0) ? 1 : 0);
            end
        end
        carrySel = 1'($urandom_range(0, 1));
        carryOr  = 1'($urandom_range(0, 1));
        carryAnd = 1'($urandom_range(0, 1));
    endtask

    always @(negedge iCLK) begin : mon
        exp_t e;
        if (bus.oVALID === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", bus.oVALID, 0);
            end else begin
                e = q.pop_front();
                chk("word", bus.oWORD, e.word);
                chk("done", bus.oDONE, e.done);
                chk("latency", cyc, e.at);
            end
        end else if (!iRST && bus.oDONE !== 1'b0) begin
            chk("done_alone", bus.oDONE, 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        bus.iSTART = 1'b0; bus.iSEL_AND = 1'b0; bus.iDATA_OR = 1'b0; bus.iDATA_AND = 1'b0;
        carrySel = 1'b0; carryOr = 1'b0; carryAnd = 1'b0;
        repeat (3) @(posedge iCLK);
        #1 iRST = 1'b0;
        @(negedge iCLK);
        chk("reset_word", bus.oWORD, 0);
        chk("reset_valid", bus.oVALID, 0);
        chk("reset_done", bus.oDONE, 0);
        chk("reset_busy", bus.oBUSY, 0);

        fill(1, 1'b0);                              // all ones, OR mode
        run_frame(1'b0, NPIX);   idle(6, 1'b1);

        fill(0, 1'b0); img[0][0] = 1'b1;            // single corner pixel
        run_frame(1'b0, NPIX);   idle(6, 1'b1);

        fill(0, 1'b0); img[2][2] = 1'b1;
        run_frame(1'b0, NPIX);   idle(6, 1'b1);

        fill(1, 1'b0); img[5][5] = 1'b0;            // AND mode, then back-to-back frame
        run_frame(1'b1, NPIX);
        fill(0, 1'b1);
        run_frame(1'b0, NPIX);   idle(6, 1'b1);

        fill(0, 1'b1);                              // abort at cycle 60, restart
        run_frame(1'b1, 60);
        fill(1, 1'b0);
        run_frame(1'b0, NPIX);   idle(6, 1'b1);

        fill(0, 1'b1);                              // reset at cycle 30
        run_frame(1'b0, 30);
        @(posedge iCLK); #1;
        iRST = 1'b1;
        bus.iSTART = 1'b0;
        @(posedge iCLK); #1;
        iRST = 1'b0;
        @(negedge iCLK);
        chk("rst_mid_word", bus.oWORD, 0);
        chk("rst_mid_valid", bus.oVALID, 0);
        chk("rst_mid_done", bus.oDONE, 0);
        chk("rst_mid_busy", bus.oBUSY, 0);
        idle(80, 1'b0);

        fill(0, 1'b1);
        run_frame(1'b1, NPIX);   idle(6, 1'b1);

        chk("drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
